partition_reader: RTL

PARTITION_READER -- requirements
Module: partition_reader

---
 rtl/graph_pkg.sv | 13 +
 rtl/partition_reader_if.sv | 23 ++
 rtl/pr_skid_fifo.sv | 43 ++++
 rtl/partition_reader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// rtl/graph_pkg.sv - shared sizing constants and FSM state type for the partition reader
package graph_pkg;
    localparam int Q      = 16;
    localparam int K      = 16;
    localparam int VID_BW = 16;
    localparam int CPP    = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } pr_state_t;
endpackage

// File: rtl/partition_reader_if.sv
// rtl/partition_reader_if.sv - SRAM read port and chunk output stream bundle
interface partition_reader_if #(
    parameter int DW = 256,
    parameter int AW = 10
);
    logic          sram_re;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output sram_re, sram_addr, out_valid, out_data, out_last,
        input  sram_rdata, out_ready
    );

    modport slave (
        input  sram_re, sram_addr, out_valid, out_data, out_last,
        output sram_rdata, out_ready
    );
endinterface

// File: rtl/pr_skid_fifo.sv
// rtl/pr_skid_fifo.sv - two-entry skid FIFO absorbing SRAM returns under output backpressure
module pr_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic         do_wr;
    logic         do_rd;

    assign do_wr   = wr_en && (count != 2'd2);
    assign do_rd   = rd_en && (count != 2'd0);
    assign empty   = (count == 2'd0);
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= wr_data;
                wptr      <= ~wptr;
            end
            if (do_rd) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, do_wr} - {1'b0, do_rd};
        end
    end
endmodule

// File: rtl/partition_reader.sv
// rtl/partition_reader.sv - per-partition chunk counting and SRAM drain to a chunk stream
// Optional beat counter output enabled by defining PARTITION_READER_BEATCNT_EN.
module partition_reader #(
    parameter int Q      = graph_pkg::Q,
    parameter int K      = graph_pkg::K,
    parameter int VID_BW = graph_pkg::VID_BW,
    parameter int CPP    = graph_pkg::CPP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [$clog2(K)-1:0]     commit_part,
    input  logic                     start,
    input  logic [$clog2(K)-1:0]     start_part,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf,
`ifdef PARTITION_READER_BEATCNT_EN
    output logic [$clog2(CPP+1)-1:0] beat_cnt,
`endif
    partition_reader_if.master       bus
);
    import graph_pkg::*;

    localparam int PW = $clog2(K);
    localparam int AW = $clog2(K*CPP);
    localparam int CW = $clog2(CPP+1);
    localparam int DW = Q*VID_BW;
    localparam logic [CW-1:0] CPP_C = CW'(CPP);
    localparam logic [AW-1:0] CPP_A = AW'(CPP);

    pr_state_t     state;
    logic [CW-1:0] cnt [K];
    logic [PW-1:0] part;
    logic [CW-1:0] snap;
    logic [CW-1:0] rd;
    logic          inflight;
    logic          inflight_last;
    logic [1:0]    fifo_count;
    logic          fifo_empty;
    logic [DW:0]   fifo_rdata;
    logic          pop;
    logic          issue;
    logic          issue_last;
    logic          drain_end;
    logic [PW-1:0] rd_part;
    logic [CW-1:0] rd_idx;

    assign pop       = !fifo_empty && bus.out_ready;
    assign drain_end = (state == ST_DRAIN) && pop && fifo_rdata[DW];
    assign busy      = (state != ST_IDLE);

    // First read goes out in the start cycle so the first beat can appear two cycles later;
    // a beat leaving this cycle frees its slot, which keeps one read per cycle sustainable.
    always_comb begin
        issue      = 1'b0;
        issue_last = 1'b0;
        rd_part    = part;
        rd_idx     = rd;
        if (!rst) begin
            if (state == ST_IDLE && start && cnt[start_part] != '0) begin
                issue      = 1'b1;
                issue_last = (cnt[start_part] == CW'(1));
                rd_part    = start_part;
                rd_idx     = '0;
            end else if (state == ST_READ &&
                         ({1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2) begin
                issue      = 1'b1;
                issue_last = (rd == snap - CW'(1));
            end
        end
    end

    assign bus.sram_re   = issue;
    assign bus.sram_addr = issue ? (AW'(rd_part) * CPP_A + AW'(rd_idx)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            part          <= '0;
            snap          <= '0;
            rd            <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
            ovf           <= 1'b0;
            for (int k = 0; k < K; k++) cnt[k] <= '0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue_last;
            for (int k = 0; k < K; k++) begin
                if (drain_end && PW'(k) == part) begin
                    cnt[k] <= cnt[k] - snap +
                              ((commit_valid && commit_part == part) ? CW'(1) : CW'(0));
                end else if (commit_valid && commit_part == PW'(k)) begin
                    if (cnt[k] == CPP_C) ovf <= 1'b1;
                    else                 cnt[k] <= cnt[k] + CW'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        part <= start_part;
                        snap <= cnt[start_part];
                        rd   <= issue ? CW'(1) : '0;
                        if (cnt[start_part] == '0)        done  <= 1'b1;
                        else if (cnt[start_part] == CW'(1)) state <= ST_DRAIN;
                        else                               state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd <= rd + CW'(1);
                        if (issue_last) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_end) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pr_skid_fifo #(.W(DW+1)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight),
        .wr_data ({inflight_last, bus.sram_rdata}),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_rdata[DW-1:0];
    assign bus.out_last  = !fifo_empty && fifo_rdata[DW];

`ifdef PARTITION_READER_BEATCNT_EN
    logic start_ok;
    assign start_ok = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst || start_ok) beat_cnt <= '0;
        else if (pop)        beat_cnt <= beat_cnt + CW'(1);
    end
`endif
endmodule
